// File: rtl/pulse_channel.sv
// pulse_channel: NES-style pulse voice with duty sequencer, envelope, length counter and sweep.
module pulse_channel #(
  parameter int CHANNEL = 0,
  parameter int TIMER_W = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       ch_enable,
  input  logic       apu_tick,
  input  logic       quarter_frame,
  input  logic       half_frame,
  output logic [3:0] vol,
  output logic       active
);
  localparam logic [31:0] DUTY_SEQ = {8'hF9, 8'h1E, 8'h06, 8'h02};
  localparam logic [7:0] LEN [32] = '{
    8'd10, 8'd254, 8'd20, 8'd2, 8'd40, 8'd4, 8'd80, 8'd6,
    8'd160, 8'd8, 8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12, 8'd16, 8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };
  localparam logic [TIMER_W:0] NEG_ADJ = (TIMER_W+1)'(CHANNEL == 0 ? 1 : 0);
  logic [1:0]         duty;
  logic               halt, const_vol, sweep_en, negate, env_start, sweep_reload;
  logic [3:0]         env_v, decay, env_div;
  logic [2:0]         sweep_p, shift, step, sdiv;
  logic [TIMER_W-1:0] period, timer;
  logic [7:0]         length;
  logic [TIMER_W:0]   delta, target;
  logic               mute, duty_bit;
  always_comb begin
    delta    = {1'b0, period} >> shift;
    target   = negate ? {1'b0, period} - delta - NEG_ADJ : {1'b0, period} + delta;
    mute     = (period < TIMER_W'(8)) || (!negate && target[TIMER_W]);
    duty_bit = DUTY_SEQ[{duty, step}];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {duty, halt, const_vol, env_v} <= '0;
      {sweep_en, sweep_p, negate, shift} <= '0;
      period       <= '0;
      timer        <= '0;
      step         <= '0;
      env_start    <= 1'b0;
      decay        <= '0;
      env_div      <= '0;
      sdiv         <= '0;
      sweep_reload <= 1'b0;
      length       <= '0;
      vol          <= '0;
      active       <= 1'b0;
    end else begin
      if (apu_tick) begin
        if (timer == '0) begin
          timer <= period;
          step  <= step + 3'd1;
        end else timer <= timer - 1'b1;
      end
      if (quarter_frame) begin
        if (env_start) begin
          env_start <= 1'b0;
          decay     <= 4'hF;
          env_div   <= env_v;
        end else if (env_div == '0) begin
          env_div <= env_v;
          if (decay != '0) decay <= decay - 1'b1;
          else if (halt) decay <= 4'hF;
        end else env_div <= env_div - 1'b1;
      end
      if (half_frame) begin
        if (sdiv == '0 && sweep_en && shift != '0 && !mute) period <= target[TIMER_W-1:0];
        if (sdiv == '0 || sweep_reload) begin
          sdiv         <= sweep_p;
          sweep_reload <= 1'b0;
        end else sdiv <= sdiv - 1'b1;
        if (!halt && length != '0) length <= length - 1'b1;
      end
      // register writes come last so they override same-cycle tick updates
      if (wr_en && wr_addr == 2'd0) {duty, halt, const_vol, env_v} <= wr_data;
      if (wr_en && wr_addr == 2'd1) begin
        {sweep_en, sweep_p, negate, shift} <= wr_data;
        sweep_reload <= 1'b1;
      end
      if (wr_en && wr_addr == 2'd2) period[7:0] <= wr_data;
      if (wr_en && wr_addr == 2'd3) begin
        period[TIMER_W-1:8] <= wr_data[TIMER_W-9:0];
        if (ch_enable) length <= LEN[wr_data[7:3]];
        step      <= '0;
        env_start <= 1'b1;
      end
      if (!ch_enable) length <= '0;
      vol    <= (mute || length == '0 || !duty_bit) ? 4'd0 : (const_vol ? env_v : decay);
      active <= length != '0;
    end
  end
endmodule

// File: tb/tb_pulse_channel.sv
// tb_pulse_channel: directed scoreboard bench for both pulse_channel negate variants.
module tb_pulse_channel;
  logic       clk = 1'b0;
  logic       rst, wr_en, ch_enable, apu_tick, quarter_frame, half_frame;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] vol, vol1;
  logic       active, active1;
  typedef struct {
    string      tag;
    logic [3:0] vol;
    logic       act;
  } exp_t;
  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pulse_channel #(.CHANNEL(0), .TIMER_W(11)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ch_enable(ch_enable), .apu_tick(apu_tick), .quarter_frame(quarter_frame),
    .half_frame(half_frame), .vol(vol), .active(active)
  );
  pulse_channel #(.CHANNEL(1), .TIMER_W(11)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ch_enable(ch_enable), .apu_tick(apu_tick), .quarter_frame(quarter_frame),
    .half_frame(half_frame), .vol(vol1), .active(active1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_q();
    quarter_frame = 1'b1;
    cyc();
    quarter_frame = 1'b0;
  endtask

  task automatic pulse_h();
    half_frame = 1'b1;
    cyc();
    half_frame = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; ch_enable = 1'b0;
    apu_tick = 1'b0; quarter_frame = 1'b0; half_frame = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] v, input logic a);
    exp_t e;
    e.tag = tag; e.vol = v; e.act = a;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: vol=%0d active=%0b with no expected entry", vol, active);
    end else begin
      e = exp_q.pop_front();
      assert (vol === e.vol && active === e.act) else begin
        miscompares++;
        $error("FAIL %s: vol=%0d active=%0b expected vol=%0d active=%0b", e.tag, vol, active, e.vol, e.act);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%03h expected 0x%03h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; ch_enable = 1'b0;
    apu_tick = 1'b0; quarter_frame = 1'b0; half_frame = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    expect_out("reset", 4'd0, 1'b0);
    check_out();

    // duty 2, constant volume 15; period 3 is below the mute threshold
    ch_enable = 1'b1;
    wr(2'd0, 8'hBF);
    wr(2'd2, 8'h03);
    wr(2'd3, 8'h08);
    expect_out("short_period_mute", 4'd0, 1'b1);
    cyc();
    check_out();
    wr(2'd2, 8'h08);
    cyc();
    apu_tick = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      s = ((k - 1 + 8) / 9) % 8;
      expect_out("duty2_wave", (s >= 1 && s <= 4) ? 4'd15 : 4'd0, 1'b1);
      cyc();
      check_out();
    end
    apu_tick = 1'b0;

    // envelope decay, V=5, duty 3 so step 0 is high
    do_reset();
    ch_enable = 1'b1;
    wr(2'd0, 8'hC5);
    wr(2'd2, 8'h08);
    wr(2'd3, 8'h08);
    for (int p = 1; p <= 100; p++) begin
      d = 15 - (p - 1) / 6;
      if (d < 0) d = 0;
      expect_out("env_decay", 4'(d), 1'b1);
      pulse_q();
      cyc();
      check_out();
    end
    wr(2'd0, 8'hE5);
    for (int i = 1; i <= 9; i++) begin
      expect_out("env_loop", (i < 3) ? 4'd0 : ((i < 9) ? 4'd15 : 4'd14), 1'b1);
      pulse_q();
      cyc();
      check_out();
    end

    // sweep add, negate variants, divider
    do_reset();
    ch_enable = 1'b1;
    wr(2'd0, 8'hBF);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd1, 8'h81);
    pulse_h();
    check_val("sweep_add_1", 12'(u0.period), 12'h180);
    pulse_h();
    check_val("sweep_add_2", 12'(u0.period), 12'h240);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd1, 8'h89);
    pulse_h();
    check_val("sweep_neg_ch0", 12'(u0.period), 12'h07F);
    check_val("sweep_neg_ch1", 12'(u1.period), 12'h080);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd1, 8'h91);
    pulse_h();
    check_val("sweep_div_1", 12'(u0.period), 12'h180);
    pulse_h();
    check_val("sweep_div_2", 12'(u0.period), 12'h180);
    pulse_h();
    check_val("sweep_div_3", 12'(u0.period), 12'h240);

    // sweep overflow and low-period muting
    do_reset();
    ch_enable = 1'b1;
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'h81);
    wr(2'd2, 8'hF0);
    wr(2'd3, 8'h0F);
    expect_out("sweep_overflow_mute", 4'd0, 1'b1);
    cyc();
    check_out();
    pulse_h();
    check_val("overflow_period_hold", 12'(u0.period), 12'h7F0);
    wr(2'd3, 8'h0B);
    expect_out("sweep_no_mute", 4'd15, 1'b1);
    cyc();
    check_out();
    wr(2'd2, 8'h05);
    wr(2'd3, 8'h08);
    expect_out("period_5_mute", 4'd0, 1'b1);
    cyc();
    check_out();
    wr(2'd2, 8'h08);
    expect_out("period_8_audible", 4'd15, 1'b1);
    cyc();
    check_out();

    // length counter expiry and channel disable
    do_reset();
    ch_enable = 1'b1;
    wr(2'd0, 8'hDF);
    wr(2'd2, 8'h08);
    wr(2'd3, 8'h18);
    expect_out("len2_loaded", 4'd15, 1'b1);
    cyc();
    check_out();
    expect_out("len_after_1", 4'd15, 1'b1);
    pulse_h();
    cyc();
    check_out();
    expect_out("len_expired", 4'd0, 1'b0);
    pulse_h();
    cyc();
    check_out();
    wr(2'd3, 8'h08);
    expect_out("len254", 4'd15, 1'b1);
    cyc();
    check_out();
    ch_enable = 1'b0;
    expect_out("ch_disable", 4'd0, 1'b0);
    cyc();
    cyc();
    check_out();
    wr(2'd3, 8'h08);
    expect_out("load_while_disabled", 4'd0, 1'b0);
    cyc();
    check_out();
    check_val("len_disabled", 12'(u0.length), 12'd0);

    // mid-waveform reset, then load coincident with half_frame
    do_reset();
    ch_enable = 1'b1;
    wr(2'd0, 8'hDF);
    wr(2'd2, 8'h08);
    wr(2'd3, 8'h08);
    expect_out("pre_reset", 4'd15, 1'b1);
    cyc();
    check_out();
    rst = 1'b1; apu_tick = 1'b1; half_frame = 1'b1;
    expect_out("mid_reset", 4'd0, 1'b0);
    cyc();
    check_out();
    rst = 1'b0; apu_tick = 1'b0; half_frame = 1'b0;
    wr(2'd0, 8'hDF);
    wr(2'd2, 8'h08);
    half_frame = 1'b1;
    wr(2'd3, 8'h18);
    half_frame = 1'b0;
    check_val("load_beats_decrement", 12'(u0.length), 12'd2);
    expect_out("len_wr_hf_0", 4'd15, 1'b1);
    cyc();
    check_out();
    expect_out("len_wr_hf_1", 4'd15, 1'b1);
    pulse_h();
    cyc();
    check_out();
    expect_out("len_wr_hf_2", 4'd0, 1'b0);
    pulse_h();
    cyc();
    check_out();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
